mcdf_chnl_arbiter: RTL

MCDF_CHNL_ARBITER -- requirements
Module: mcdf_chnl_arbiter

---
 rtl/mcdf_pkg.sv | 30 +++
 rtl/mcdf_rr_picker.sv | 48 ++++
 rtl/mcdf_chnl_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mcdf_pkg.sv
// Shared types and constants for the MCDF channel arbiter slice.
// Latency: n/a (declarations and a pure decode function only).
// Backpressure: n/a.
// Contents: arbiter state enum, channel/data/counter widths, burst length decode.
package mcdf_pkg;

  localparam int CH_NUM = 3;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Burst length code to (length - 1), so it loads straight into the beat
  // counter and the last beat is the one where the counter reads zero.
  function automatic logic [CNT_W-1:0] len_m1(input logic [1:0] code);
    logic [CNT_W-1:0] r;
    r = 5'd3;
    case (code)
      2'd0:    r = 5'd3;
      2'd1:    r = 5'd7;
      2'd2:    r = 5'd15;
      default: r = 5'd31;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mcdf_rr_picker.sv
// Combinational 3-way round-robin select over the request vector.
// Latency: zero cycles (pure combinational).
// Backpressure: none; result is consumed only when the arbiter is idle.
// Ports: req_i request vector, rr_ptr_i last-served channel,
//        gnt_vld_o any request present, gnt_idx_o selected channel.
module mcdf_rr_picker
  import mcdf_pkg::*;
(
  input  logic [CH_NUM-1:0] req_i,
  input  logic [1:0]        rr_ptr_i,
  output logic              gnt_vld_o,
  output logic [1:0]        gnt_idx_o
);

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [1:0] base;
  logic [1:0] c0;
  logic [1:0] c1;
  logic [1:0] c2;

  always_comb begin
    // A pointer of 3 cannot occur; fold it onto 2 so every candidate indexes
    // a real channel.
    base = (rr_ptr_i > 2'd2) ? 2'd2 : rr_ptr_i;
    // Search order: the channel after the last-served one first, the
    // last-served channel itself last.
    c0 = nxt(base);
    c1 = nxt(c0);
    c2 = base;

    gnt_vld_o = 1'b0;
    gnt_idx_o = 2'd0;
    if (req_i[c0]) begin
      gnt_vld_o = 1'b1;
      gnt_idx_o = c0;
    end else if (req_i[c1]) begin
      gnt_vld_o = 1'b1;
      gnt_idx_o = c1;
    end else if (req_i[c2]) begin
      gnt_vld_o = 1'b1;
      gnt_idx_o = c2;
    end
  end

endmodule

// File: rtl/mcdf_chnl_arbiter.sv
// Round-robin burst arbiter merging three channel streams onto one output.
// Latency: one IDLE cycle to grant, then zero-cycle pass-through per beat.
// Backpressure: out_ready routes straight to the granted channel's ready;
//               a granted channel dropping valid stalls the burst in place.
// Ports: clk/reset (sync, active-high); chN_data/chN_valid/chN_ready channel
//        inputs; cfg_en enable mask and cfg_pkt_len length code, sampled at
//        grant; out_data/out_valid/out_ready/out_id/out_sop/out_eop toward the
//        formatter; busy high while a burst is in progress.
module mcdf_chnl_arbiter
  import mcdf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic [DATA_W-1:0] ch1_data,
  input  logic [DATA_W-1:0] ch2_data,
  input  logic              ch0_valid,
  input  logic              ch1_valid,
  input  logic              ch2_valid,
  output logic              ch0_ready,
  output logic              ch1_ready,
  output logic              ch2_ready,
  input  logic [2:0]        cfg_en,
  input  logic [1:0]        cfg_pkt_len,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_id,
  output logic              out_sop,
  output logic              out_eop,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sop_q, sop_d;

  logic [CH_NUM-1:0] ch_valid;
  logic [CH_NUM-1:0] ch_ready;
  logic [CH_NUM-1:0] req;
  logic              pick_vld;
  logic [1:0]        pick_idx;
  logic              gnt_valid;
  logic [DATA_W-1:0] gnt_data;
  logic              in_burst;
  logic              xfer;

  assign ch_valid = {ch2_valid, ch1_valid, ch0_valid};
  assign req      = ch_valid & cfg_en;

  mcdf_rr_picker u_picker (
    .req_i     (req),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_vld_o (pick_vld),
    .gnt_idx_o (pick_idx)
  );

  // Payload mux of the registered grant.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = '0;
    case (grant_q)
      2'd0: begin
        gnt_valid = ch0_valid;
        gnt_data  = ch0_data;
      end
      2'd1: begin
        gnt_valid = ch1_valid;
        gnt_data  = ch1_data;
      end
      2'd2: begin
        gnt_valid = ch2_valid;
        gnt_data  = ch2_data;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_data  = '0;
      end
    endcase
  end

  // Outputs are masked by reset directly so an asserted reset silences the
  // interface in the same cycle, even before the state register clears.
  assign in_burst = (state_q == BURST) && !reset;

  always_comb begin
    out_valid = in_burst & gnt_valid;
    out_data  = in_burst ? gnt_data : '0;
    out_id    = in_burst ? grant_q : 2'd0;
    out_sop   = out_valid & sop_q;
    out_eop   = out_valid & (cnt_q == '0);
    busy      = in_burst;
    for (int i = 0; i < CH_NUM; i++) begin
      ch_ready[i] = in_burst && (grant_q == 2'(i)) && out_ready;
    end
  end

  assign ch0_ready = ch_ready[0];
  assign ch1_ready = ch_ready[1];
  assign ch2_ready = ch_ready[2];

  assign xfer = out_valid & out_ready;

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    sop_d    = sop_q;
    case (state_q)
      IDLE: begin
        // Enable mask and length are captured here only; later changes do
        // not reach a burst already in flight.
        if (pick_vld) begin
          state_d = BURST;
          grant_d = pick_idx;
          cnt_d   = len_m1(cfg_pkt_len);
          sop_d   = 1'b1;
        end
      end
      BURST: begin
        if (xfer) begin
          sop_d = 1'b0;
          if (cnt_q == '0) begin
            state_d  = IDLE;
            rr_ptr_d = grant_q;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 2'd0;
      rr_ptr_q <= 2'd2;
      cnt_q    <= '0;
      sop_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      sop_q    <= sop_d;
    end
  end

  // Only three channels exist; index 3 would select nothing and stall forever.
  a_grant_range: assert property (@(posedge clk) disable iff (reset) grant_q != 2'd3);

endmodule
